// File: rtl/onc16_pl.sv
// onc16_pl: 16-bit 5-stage in-order pipelined CPU (IF/ID/EX/MEM/WB), Harvard memory ports.
// Optional HALT instruction (op 0xF) is compiled in when ONC16_HALT_EN is defined.
module onc16_pl #(
  parameter int DATA_W = 16,
  parameter int INST_W = 16,
  parameter int REG_N  = 8
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              en,
  input  logic [INST_W-1:0] imem_din,
  input  logic [DATA_W-1:0] dmem_din,
  output logic [DATA_W-1:0] imem_addr,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_dout,
  output logic              dmem_we
);

  typedef enum logic [3:0] {
    OP_ALU  = 4'h0, OP_ADDI = 4'h1, OP_LI  = 4'h2, OP_LD  = 4'h3,
    OP_ST   = 4'h4, OP_BEQ  = 4'h5, OP_BNE = 4'h6, OP_JMP = 4'h7,
    OP_HALT = 4'hF
  } op_e;

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ifid_inst_q, ifid_inst_d, idex_inst_q, idex_inst_d;
  logic [DATA_W-1:0] ifid_pc_q, ifid_pc_d, idex_pc_q, idex_pc_d;
  logic [DATA_W-1:0] idex_va_q, idex_va_d, idex_vb_q, idex_vb_d, idex_vc_q, idex_vc_d;
  op_e               exmem_op_q, exmem_op_d;
  logic              exmem_wr_q, exmem_wr_d, memwb_wr_q, memwb_wr_d;
  logic [2:0]        exmem_dest_q, exmem_dest_d, memwb_dest_q, memwb_dest_d;
  logic [DATA_W-1:0] exmem_res_q, exmem_res_d, exmem_sdata_q, exmem_sdata_d;
  logic [DATA_W-1:0] memwb_res_q, memwb_res_d;
  logic [DATA_W-1:0] rf_q [REG_N];
  logic [DATA_W-1:0] rf_d [REG_N];

  op_e               id_op, ex_op;
  logic [2:0]        id_a, id_b, id_c, ex_dest;
  logic              load_use, halt_id, hold_id;
  logic [DATA_W-1:0] ex_va, ex_vb, ex_vc, ex_imm, ex_alu, ex_res, ex_target;
  logic              ex_taken;

  function automatic logic writes_ra(input op_e op);
    return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LI) || (op == OP_LD);
  endfunction

  function automatic logic uses_a(input op_e op);
    return (op == OP_ST) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic uses_b(input op_e op);
    return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LD) || uses_a(op);
  endfunction

  // Write-before-read: the WB result is bypassed straight into the ID read.
  function automatic logic [DATA_W-1:0] rf_read(input logic [2:0] idx);
    if (idx == 3'd0) return '0;
    if (memwb_wr_q && (memwb_dest_q == idx)) return memwb_res_q;
    return rf_q[idx];
  endfunction

  // The *_wr flags are already cleared for r0, so r0 never forwards.
  function automatic logic [DATA_W-1:0] fwd(input logic [2:0] idx, input logic [DATA_W-1:0] idv);
    if (exmem_wr_q && (exmem_dest_q == idx)) return exmem_res_q;
    if (memwb_wr_q && (memwb_dest_q == idx)) return memwb_res_q;
    return idv;
  endfunction

  assign id_op   = op_e'(ifid_inst_q[15:12]);
  assign id_a    = ifid_inst_q[11:9];
  assign id_b    = ifid_inst_q[8:6];
  assign id_c    = ifid_inst_q[5:3];
  assign ex_op   = op_e'(idex_inst_q[15:12]);
  assign ex_dest = idex_inst_q[11:9];

`ifdef ONC16_HALT_EN
  assign halt_id = (id_op == OP_HALT);
`else
  assign halt_id = 1'b0;
`endif

  always_comb begin
    load_use = (ex_op == OP_LD) && (ex_dest != 3'd0) &&
               ((uses_a(id_op) && (id_a == ex_dest)) ||
                (uses_b(id_op) && (id_b == ex_dest)) ||
                ((id_op == OP_ALU) && (id_c == ex_dest)));
    hold_id  = load_use || halt_id;
  end

  always_comb begin
    ex_va     = fwd(idex_inst_q[11:9], idex_va_q);
    ex_vb     = fwd(idex_inst_q[8:6], idex_vb_q);
    ex_vc     = fwd(idex_inst_q[5:3], idex_vc_q);
    ex_imm    = {{(DATA_W-6){idex_inst_q[5]}}, idex_inst_q[5:0]};
    ex_alu    = '0;
    ex_res    = '0;
    ex_taken  = 1'b0;
    ex_target = idex_pc_q + DATA_W'(1) + ex_imm;
    case (idex_inst_q[2:0])
      3'd0:    ex_alu = ex_vb + ex_vc;
      3'd1:    ex_alu = ex_vb - ex_vc;
      3'd2:    ex_alu = ex_vb & ex_vc;
      3'd3:    ex_alu = ex_vb | ex_vc;
      3'd4:    ex_alu = ex_vb ^ ex_vc;
      3'd5:    ex_alu = ex_vb << ex_vc[3:0];
      3'd6:    ex_alu = ex_vb >> ex_vc[3:0];
      default: ex_alu = {{(DATA_W-1){1'b0}}, ($signed(ex_vb) < $signed(ex_vc))};
    endcase
    case (ex_op)
      OP_ALU:                ex_res = ex_alu;
      OP_ADDI, OP_LD, OP_ST: ex_res = ex_vb + ex_imm;
      OP_LI:                 ex_res = {{(DATA_W-9){idex_inst_q[8]}}, idex_inst_q[8:0]};
      OP_BEQ:                ex_taken = (ex_va == ex_vb);
      OP_BNE:                ex_taken = (ex_va != ex_vb);
      OP_JMP: begin
        ex_taken  = 1'b1;
        ex_target = {{(DATA_W-12){1'b0}}, idex_inst_q[11:0]};
      end
      default: ;
    endcase
  end

  // Flush wins over stall/halt; a stall/halt holds PC and IF/ID and bubbles EX.
  always_comb begin
    pc_d        = pc_q + DATA_W'(1);
    ifid_inst_d = imem_din;
    ifid_pc_d   = pc_q;
    idex_inst_d = ifid_inst_q;
    idex_pc_d   = ifid_pc_q;
    idex_va_d   = rf_read(id_a);
    idex_vb_d   = rf_read(id_b);
    idex_vc_d   = rf_read(id_c);
    if (ex_taken) begin
      pc_d        = ex_target;
      ifid_inst_d = '0;
    end else if (hold_id) begin
      pc_d        = pc_q;
      ifid_inst_d = ifid_inst_q;
      ifid_pc_d   = ifid_pc_q;
    end
    if (ex_taken || hold_id) begin
      idex_inst_d = '0;
      idex_va_d   = '0;
      idex_vb_d   = '0;
      idex_vc_d   = '0;
    end
    exmem_op_d    = ex_op;
    exmem_wr_d    = writes_ra(ex_op) && (ex_dest != 3'd0);
    exmem_dest_d  = ex_dest;
    exmem_res_d   = ex_res;
    exmem_sdata_d = ex_va;
    memwb_wr_d    = exmem_wr_q;
    memwb_dest_d  = exmem_dest_q;
    memwb_res_d   = (exmem_op_q == OP_LD) ? dmem_din : exmem_res_q;
    rf_d          = rf_q;
    if (memwb_wr_q) rf_d[memwb_dest_q] = memwb_res_q;
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      pc_q          <= '0;
      ifid_inst_q   <= '0;
      ifid_pc_q     <= '0;
      idex_inst_q   <= '0;
      idex_pc_q     <= '0;
      idex_va_q     <= '0;
      idex_vb_q     <= '0;
      idex_vc_q     <= '0;
      exmem_op_q    <= OP_ALU;
      exmem_wr_q    <= 1'b0;
      exmem_dest_q  <= '0;
      exmem_res_q   <= '0;
      exmem_sdata_q <= '0;
      memwb_wr_q    <= 1'b0;
      memwb_dest_q  <= '0;
      memwb_res_q   <= '0;
      for (int unsigned k = 0; k < REG_N; k++) rf_q[k] <= '0;
    end else if (en) begin
      pc_q          <= pc_d;
      ifid_inst_q   <= ifid_inst_d;
      ifid_pc_q     <= ifid_pc_d;
      idex_inst_q   <= idex_inst_d;
      idex_pc_q     <= idex_pc_d;
      idex_va_q     <= idex_va_d;
      idex_vb_q     <= idex_vb_d;
      idex_vc_q     <= idex_vc_d;
      exmem_op_q    <= exmem_op_d;
      exmem_wr_q    <= exmem_wr_d;
      exmem_dest_q  <= exmem_dest_d;
      exmem_res_q   <= exmem_res_d;
      exmem_sdata_q <= exmem_sdata_d;
      memwb_wr_q    <= memwb_wr_d;
      memwb_dest_q  <= memwb_dest_d;
      memwb_res_q   <= memwb_res_d;
      rf_q          <= rf_d;
    end
  end

  assign imem_addr = pc_q;
  assign dmem_addr = exmem_res_q;
  assign dmem_dout = exmem_sdata_q;
  assign dmem_we   = en && (exmem_op_q == OP_ST);

endmodule

// File: tb/tb_onc16_pl.sv
// Directed bench for onc16_pl: per-cycle vector tables of {en, imem_addr, dmem_we/addr/dout}.
module tb_onc16_pl;
  logic        clock = 1'b0;
  logic        n_rst, en;
  logic [15:0] imem_din, dmem_din, imem_addr, dmem_addr, dmem_dout;
  logic        dmem_we;
  logic [15:0] prog [64];
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic        en;
    logic [15:0] pc;
    logic        we;
    logic [15:0] addr;
    logic [15:0] dout;
  } vec_t;
  vec_t vecs[$];

  onc16_pl #(.DATA_W(16), .INST_W(16), .REG_N(8)) dut (
    .clock(clock), .n_rst(n_rst), .en(en), .imem_din(imem_din), .dmem_din(dmem_din),
    .imem_addr(imem_addr), .dmem_addr(dmem_addr), .dmem_dout(dmem_dout), .dmem_we(dmem_we)
  );

  always #5 clock = ~clock;
  assign imem_din = (imem_addr < 16'd64) ? prog[imem_addr[5:0]] : 16'h0000;

  function automatic logic [15:0] enc_r(input int fn, input int a, input int b, input int c);
    return {4'h0, a[2:0], b[2:0], c[2:0], fn[2:0]};
  endfunction
  function automatic logic [15:0] enc_i(input int op, input int a, input int b, input int imm);
    return {op[3:0], a[2:0], b[2:0], imm[5:0]};
  endfunction
  function automatic logic [15:0] enc_li(input int a, input int imm);
    return {4'h2, a[2:0], imm[8:0]};
  endfunction
  function automatic logic [15:0] enc_jmp(input int t);
    return {4'h7, t[11:0]};
  endfunction

  task automatic add_vec(input logic e, input logic [15:0] p, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
    vec_t v;
    v.en = e; v.pc = p; v.we = w; v.addr = a; v.dout = d;
    vecs.push_back(v);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
    vecs.delete();
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_vec(input string name, input int idx, input vec_t v);
    checks++;
    if (imem_addr !== v.pc || dmem_we !== v.we ||
        (v.we && (dmem_addr !== v.addr || dmem_dout !== v.dout))) begin
      errors++;
      $display("FAIL %s[%0d]: got pc=%h we=%b addr=%h dout=%h, want pc=%h we=%b addr=%h dout=%h",
               name, idx, imem_addr, dmem_we, dmem_addr, dmem_dout, v.pc, v.we, v.addr, v.dout);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    en = 1'b1;
    n_rst = 1'b0;
    @(negedge clock);
    n_rst = 1'b1;
  endtask

  // Entry i: en applies to edge i+1; outputs sampled just after that edge.
  task automatic run_vecs(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en;
      @(posedge clock);
      #1;
      check_vec(name, i, vecs[i]);
      @(negedge clock);
    end
    en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int pcs5 [25] = '{1,2,3,4,5,6,7,3,4,5,6,7,3,4,5,6,7,3,4,5,6,7,8,9,10};
    logic [15:0] alu_exp [9] = '{16'h0012, 16'hFFE8, 16'h0015, 16'hFFFD, 16'hFFE8,
                                 16'hFFA0, 16'h07FF, 16'h0001, 16'h0000};
    n_rst = 1'b1;
    en = 1'b1;
    dmem_din = 16'h0100;
    clear_prog();

    // Reset state, then a NOP program fetching sequentially
    #2 n_rst = 1'b0;
    #1;
    check_val("rst_imem_addr", imem_addr, 16'h0000);
    check_val("rst_dmem_addr", dmem_addr, 16'h0000);
    check_val("rst_dmem_dout", dmem_dout, 16'h0000);
    check_val("rst_dmem_we", {15'b0, dmem_we}, 16'h0000);
    @(posedge clock);
    #1 check_val("rst_hold_pc", imem_addr, 16'h0000);
    @(negedge clock);
    n_rst = 1'b1;
    for (int i = 1; i <= 6; i++) add_vec(1, 16'(i), 0, 0, 0);
    run_vecs("fetch");

    // Forwarding chain with en dropped while a store sits in MEM
    clear_prog();
    prog[0] = enc_li(1, 5);
    prog[1] = enc_li(2, 7);
    prog[2] = enc_r(0, 3, 1, 2);
    prog[3] = enc_i(4, 3, 0, 0);
    prog[4] = enc_i(1, 3, 3, 1);
    prog[5] = enc_i(1, 3, 3, 1);
    prog[6] = enc_i(4, 3, 0, 1);
    for (int i = 1; i <= 5; i++) add_vec(1, 16'(i), 0, 0, 0);
    add_vec(1, 6, 1, 16'h0000, 16'd12);
    add_vec(0, 6, 0, 0, 0);
    add_vec(1, 7, 0, 0, 0);
    add_vec(1, 8, 0, 0, 0);
    add_vec(1, 9, 1, 16'h0001, 16'd14);
    add_vec(1, 10, 0, 0, 0);
    do_reset();
    run_vecs("fwd");

    // Asynchronous reset with a store in MEM
    vecs.delete();
    for (int i = 1; i <= 5; i++) add_vec(1, 16'(i), 0, 0, 0);
    add_vec(1, 6, 1, 16'h0000, 16'd12);
    do_reset();
    run_vecs("pre_rst");
    check_val("mid_we_before", {15'b0, dmem_we}, 16'h0001);
    n_rst = 1'b0;
    #1;
    check_val("mid_rst_pc", imem_addr, 16'h0000);
    check_val("mid_rst_we", {15'b0, dmem_we}, 16'h0000);
    check_val("mid_rst_dout", dmem_dout, 16'h0000);
    @(negedge clock);
    n_rst = 1'b1;
    vecs.delete();
    add_vec(1, 1, 0, 0, 0);
    run_vecs("post_rst");

    // Load-use stall, then r0 write discard
    clear_prog();
    dmem_din = 16'h0100;
    prog[0] = enc_i(3, 1, 0, 0);
    prog[1] = enc_i(1, 2, 1, 1);
    prog[2] = enc_i(4, 2, 0, 1);
    prog[3] = enc_li(0, 7);
    prog[4] = enc_i(4, 0, 0, 2);
    add_vec(1, 1, 0, 0, 0);
    add_vec(1, 2, 0, 0, 0);
    add_vec(1, 2, 0, 0, 0);
    add_vec(1, 3, 0, 0, 0);
    add_vec(1, 4, 0, 0, 0);
    add_vec(1, 5, 1, 16'h0001, 16'h0101);
    add_vec(1, 6, 0, 0, 0);
    add_vec(1, 7, 1, 16'h0002, 16'h0000);
    add_vec(1, 8, 0, 0, 0);
    do_reset();
    run_vecs("ldu");

    // Branch flushes: BNE, JMP, BEQ
    clear_prog();
    prog[0]  = enc_li(1, 1);
    prog[1]  = enc_i(6, 1, 0, 2);
    prog[2]  = enc_li(4, 9);
    prog[3]  = enc_li(4, 9);
    prog[4]  = enc_i(4, 4, 0, 2);
    prog[5]  = enc_jmp(8);
    prog[6]  = enc_li(5, 1);
    prog[7]  = enc_li(5, 1);
    prog[8]  = enc_i(5, 4, 0, 1);
    prog[9]  = enc_li(5, 2);
    prog[10] = enc_i(4, 5, 0, 3);
    begin
      int pcs4 [15] = '{1,2,3,4,5,6,7,8,9,10,10,11,12,13,14};
      for (int i = 0; i < 15; i++)
        add_vec(1, 16'(pcs4[i]), (i == 6 || i == 13), (i == 6) ? 16'd2 : 16'd3, 16'h0000);
    end
    do_reset();
    run_vecs("br");

    // Multiply loop, plain and with a 5-cycle en gap
    clear_prog();
    prog[0] = enc_li(1, 3);
    prog[1] = enc_li(2, 4);
    prog[2] = enc_li(3, 0);
    prog[3] = enc_r(0, 3, 3, 1);
    prog[4] = enc_i(1, 2, 2, -1);
    prog[5] = enc_i(6, 2, 0, -3);
    prog[6] = enc_i(4, 3, 0, 3);
    for (int i = 0; i < 25; i++) add_vec(1, 16'(pcs5[i]), (i == 23), 16'd3, 16'd12);
    do_reset();
    run_vecs("mul");
    vecs.delete();
    for (int i = 0; i < 30; i++) begin
      if (i < 9)       add_vec(1, 16'(pcs5[i]), 0, 0, 0);
      else if (i < 14) add_vec(0, 16'(pcs5[8]), 0, 0, 0);
      else             add_vec(1, 16'(pcs5[i-5]), (i == 28), 16'd3, 16'd12);
    end
    do_reset();
    run_vecs("mul_en");

    // All ALU functions, results stored to addresses 0..8
    clear_prog();
    prog[0] = enc_li(1, -3);
    prog[1] = enc_li(2, 21);
    for (int k = 0; k < 8; k++) begin
      prog[2+2*k] = enc_r(k, 3, 1, 2);
      prog[3+2*k] = enc_i(4, 3, 0, k);
    end
    prog[18] = enc_r(7, 3, 2, 1);
    prog[19] = enc_i(4, 3, 0, 8);
    for (int i = 0; i < 22; i++) begin
      if (i >= 5 && ((i - 5) % 2 == 0))
        add_vec(1, 16'(i + 1), 1, 16'((i - 5) / 2), alu_exp[(i - 5) / 2]);
      else
        add_vec(1, 16'(i + 1), 0, 0, 0);
    end
    do_reset();
    run_vecs("alu");

`ifdef ONC16_HALT_EN
    clear_prog();
    prog[0] = enc_i(4, 0, 0, 5);
    prog[1] = 16'hF000;
    add_vec(1, 1, 0, 0, 0);
    add_vec(1, 2, 0, 0, 0);
    add_vec(1, 2, 1, 16'd5, 16'h0000);
    for (int i = 0; i < 5; i++) add_vec(1, 2, 0, 0, 0);
    do_reset();
    run_vecs("halt");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
